// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation and FSM state
// encodings, datapath widths and a magnitude helper for signed divides.
package mdu_pkg;

    localparam int W_DATA = 32;
    localparam int W_PROD = 2 * W_DATA;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // Absolute value when the operand is treated as signed; 0x80000000
    // maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [W_DATA-1:0] mag(input logic [W_DATA-1:0] x,
                                              input logic              is_signed);
        return (is_signed && x[W_DATA-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. start_i loads
// the operands; done_o pulses in the cycle that computes the final bit,
// with quo_o/rem_o carrying the finished result in that same cycle.
// Built only when MDU_DIV_EN is defined.
module div_iter
    import mdu_pkg::*;
#(
    parameter int W          = W_DATA,
    parameter int DIV_CYCLES = W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         kill_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);

    localparam int CW = $clog2(DIV_CYCLES) + 1;

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [W:0]    shifted, diff;
    logic          ge;

    // quo_q doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = (shifted >= {1'b0, dvs_q});

    // Next-state: load on start, otherwise one shift/subtract step while active.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_o   = 1'b0;
        if (start_i) begin
            rem_d    = '0;
            quo_d    = dividend_i;
            dvs_d    = divisor_i;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (kill_i) begin
            active_d = 1'b0;
        end else if (active_q) begin
            rem_d = ge ? diff[W-1:0] : shifted[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end
        end
    end

    assign quo_o = quo_d;
    assign rem_o = rem_d;

    // Divider registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/muldiv.sv
// EX-stage multiply/divide unit owning HI/LO. Define MDU_DIV_EN to build
// the iterative divider; without it DIV/DIVU are accepted and ignored.
//
// Handshake: the pipeline holds op_valid/op/operands stable while busy=1.
// An op completes at a clock edge where busy=0; in DONE the still-present
// op_valid belongs to the finished instruction and is ignored.
module muldiv
    import mdu_pkg::*;
`ifdef MDU_DIV_EN
#(
    parameter int DIV_CYCLES = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [W_DATA-1:0] source_a,
    input  logic [W_DATA-1:0] source_b,
    input  logic              flush,
    output logic              busy,
    output logic [W_DATA-1:0] hi,
    output logic [W_DATA-1:0] lo
);

    mdu_op_t           op_e;
    mdu_state_t        state_q, state_d;
    logic [W_DATA-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [W_DATA-1:0] a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [W_PROD-1:0] ext_a, ext_b, prod;
    logic              is_mul, is_div;

    assign op_e   = mdu_op_t'(op);
    assign is_mul = (op_e == MDU_MULT) || (op_e == MDU_MULTU);

    // Sign-extend to the full product width so one unsigned multiply
    // yields the correct low 64 bits for both MULT and MULTU.
    assign ext_a = {{W_DATA{sgn_q & a_q[W_DATA-1]}}, a_q};
    assign ext_b = {{W_DATA{sgn_q & b_q[W_DATA-1]}}, b_q};
    assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
    logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic              div_start, div_kill, div_done, dsgn;
    logic [W_DATA-1:0] div_quo, div_rem;

    assign is_div = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    assign dsgn   = (op_e == MDU_DIV);

    div_iter #(
        .W          (W_DATA),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .kill_i     (div_kill),
        .dividend_i (mag(source_a, dsgn)),
        .divisor_i  (mag(source_b, dsgn)),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );
`else
    assign is_div = 1'b0;
`endif

    // Next-state, HI/LO update and stall request.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy    = 1'b0;
`ifdef MDU_DIV_EN
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div_start = 1'b0;
        div_kill  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                busy = op_valid && (is_mul || is_div);
                if (op_valid && !flush) begin
                    case (op_e)
                        MDU_MULT, MDU_MULTU: begin
                            a_d     = source_a;
                            b_d     = source_b;
                            sgn_d   = (op_e == MDU_MULT);
                            state_d = ST_MUL;
                        end
`ifdef MDU_DIV_EN
                        MDU_DIV, MDU_DIVU: begin
                            q_neg_d   = dsgn && (source_a[W_DATA-1] ^ source_b[W_DATA-1]);
                            r_neg_d   = dsgn && source_a[W_DATA-1];
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
`endif
                        MDU_MTHI: hi_d = source_a;
                        MDU_MTLO: lo_d = source_a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = prod[W_PROD-1:W_DATA];
                    lo_d    = prod[W_DATA-1:0];
                    state_d = ST_DONE;
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                busy = 1'b1;
                if (flush) begin
                    div_kill = 1'b1;
                    state_d  = ST_IDLE;
                end else if (div_done) begin
                    lo_d    = q_neg_q ? (~div_quo + 1'b1) : div_quo;
                    hi_d    = r_neg_q ? (~div_rem + 1'b1) : div_rem;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural register update; reset discards any op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
`ifdef MDU_DIV_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
`ifdef MDU_DIV_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv. Drivers push expected {HI,LO}; a monitor
// pops and compares whenever an op retires (busy falls) or a
// non-stalling op has had its write edge.
module tb_muldiv;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] source_a = '0;
  logic [31:0] source_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .source_a (source_a),
    .source_b (source_b),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int          probe_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic bit stalls(input mdu_op_t o);
    return (o == MDU_MULT) || (o == MDU_MULTU) ||
           (DIV_EN && ((o == MDU_DIV) || (o == MDU_DIVU)));
  endfunction

  task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
    model_hi = h;
    model_lo = l;
    exp_q.push_back({h, l});
    name_q.push_back(name);
  endtask

  // ---------------- monitor ----------------
  task automatic compare_next();
    logic [63:0] e;
    string       nm;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_retire: got 0x%h, expected no result", {hi, lo});
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, " hilo"}, {hi, lo}, e);
    end
  endtask

  initial begin
    logic busy_prev;
    int   probe_seen;
    busy_prev  = 1'b0;
    probe_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy_prev && !busy) compare_next();
        if (probe_req != probe_seen) begin
          probe_seen = probe_req;
          compare_next();
        end
      end
      busy_prev = busy;
    end
  end

  // ---------------- drivers ----------------
  // Issue one op at posedge+1, hold it until busy drops, count stall cycles.
  task automatic issue_op(input string name, input mdu_op_t o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] eh, input logic [31:0] el);
    int cnt;
    cnt = 0;
    expect_hilo(name, eh, el);
    op_valid = 1'b1;
    op       = o;
    source_a = a;
    source_b = b;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (cnt > 100) break;
      @(posedge clk);
      #1;
    end
    check({name, " busy_cycles"}, 64'(cnt), 64'(exp_busy));
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = MDU_NONE;
    source_a = '0;
    source_b = '0;
    if (!stalls(o)) probe_req++;
  endtask

  // Issue an op and hit it with flush (or reset) in cycle k after issue.
  task automatic abort_op(input string name, input mdu_op_t o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input bit use_rst,
                          input logic [31:0] eh, input logic [31:0] el);
    expect_hilo(name, eh, el);
    op_valid = 1'b1;
    op       = o;
    source_a = a;
    source_b = b;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst_n = 1'b0;
    else         flush = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    flush    = 1'b0;
    op_valid = 1'b0;
    op       = MDU_NONE;
    source_a = '0;
    source_b = '0;
    if (!stalls(o)) probe_req++;
    @(negedge clk);
    check({name, " busy_after"}, 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    issue_op("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue_op("multu_neg2x3", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA);
    issue_op("mult_min_max", MDU_MULT, 32'h8000_0000, 32'h7FFF_FFFF, 2, 32'hC000_0000, 32'h8000_0000);
    issue_op("multu_2p16", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 2, 32'h0000_0001, 32'h0000_0000);
    issue_op("mthi", MDU_MTHI, 32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h1234_5678, 32'h0000_0000);
    issue_op("mtlo", MDU_MTLO, 32'hCAFE_F00D, 32'h0, 0, 32'h1234_5678, 32'hCAFE_F00D);

    abort_op("flush_idle_mthi", MDU_MTHI, 32'h0BAD_0BAD, 32'h0, 0, 1'b0, model_hi, model_lo);
    abort_op("flush_idle_mult", MDU_MULT, 32'd9, 32'd9, 0, 1'b0, model_hi, model_lo);
    abort_op("flush_in_mul", MDU_MULT, 32'd9, 32'd9, 1, 1'b0, model_hi, model_lo);
    abort_op("flush_in_done", MDU_MULTU, 32'd5, 32'd7, 2, 1'b0, 32'h0, 32'd35);

`ifdef MDU_DIV_EN
    issue_op("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue_op("divu_7_0", MDU_DIVU, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    issue_op("div_min_neg1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    issue_op("mthi_after_div", MDU_MTHI, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h8000_0000);
    issue_op("div_7_neg2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    issue_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    abort_op("flush_div_it10", MDU_DIV, 32'd1000, 32'd3, 11, 1'b0, model_hi, model_lo);
`else
    issue_op("divu_off", MDU_DIVU, 32'd10, 32'd3, 0, model_hi, model_lo);
    issue_op("div_off", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, model_hi, model_lo);
`endif

    issue_op("multu_3x4", MDU_MULTU, 32'd3, 32'd4, 2, 32'h0, 32'd12);
    abort_op("reset_in_mul", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1, 1'b1, 32'h0, 32'h0);
    issue_op("mtlo_after_rst", MDU_MTLO, 32'h55AA_55AA, 32'h0, 0, 32'h0, 32'h55AA_55AA);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the run wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv.md
# muldiv

Multiply/divide unit in the EX stage, fed directly by the ALU operand selector: it consumes `source_a`/`source_b` for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. Multiplies complete in a fixed short sequence. Divides run on an iterative radix-2 divider. While an operation is in flight, the unit raises `busy` so the hazard unit holds IF/ID/EX.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: iteration count of the divider; must equal the data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `op_valid`  in  1  EX holds an MDU instruction; held stable by the pipeline while `busy`=1
- `op`  in  3  `mdu_op_t`: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- `source_a`  in  `W_DATA`  rs operand (dividend / multiplicand / MTHI-MTLO data)
- `source_b`  in  `W_DATA`  rt operand (divisor / multiplier)
- `flush`  in  1  exception/flush from the exception unit; kills an in-flight operation
- `busy`  out  1  stall request to the hazard unit
- `hi`  out  `W_DATA`  architectural HI register
- `lo`  out  `W_DATA`  architectural LO register

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, `op_valid` with MULT/MULTU:
  - Latch the operands and signedness.
  - Go to MUL.
- IDLE, `op_valid` with DIV/DIVU:
  - Latch the operand magnitudes and sign flags.
  - Load the divider and go to DIV.
- IDLE, MTHI/MTLO:
  - Write `source_a` into HI/LO at the edge.
  - Stay in IDLE; no stall.
- MUL:
  - Form the 64-bit product, signed for MULT and unsigned for MULTU.
  - Write {HI,LO} at the edge and go to DONE.
- DIV:
  - One restoring iteration per cycle, `DIV_CYCLES` cycles.
  - On the last iteration, apply the sign fixups, write LO=quotient and HI=remainder, and go to DONE.
- DONE:
  - `busy`=0, so EX advances at this edge.
  - `op_valid` is ignored, because it still shows the finished instruction.
  - Go to IDLE.
- `busy` = (state==MUL) | (state==DIV) | (state==IDLE & `op_valid` & op∈{MULT,MULTU,DIV,DIVU}).
- Signed division:
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Boundary results:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 gives LO=0xFFFFFFFF (unsigned-magnitude quotient, sign fixup still applied) and HI=dividend.
- `flush`:
  - In MUL or DIV: return to IDLE; HI/LO are unchanged.
  - In IDLE: the op is not accepted, and MTHI/MTLO are suppressed.
  - In DONE: no effect, because the result is already committed.
- Reset:
  - `hi`=0, `lo`=0, state=IDLE, divider cleared.
  - `busy`=0 provided `op_valid`=0.
  - Reset mid-operation discards the operation.

## Timing
- MULT/MULTU: 3 cycles in EX (IDLE accept, MUL, DONE). `busy` is high for 2 cycles. HI/LO are visible the cycle after MUL.
- DIV/DIVU: `DIV_CYCLES`+2 = 34 cycles in EX. `busy` is high for 33 cycles. HI/LO are visible in DONE.
- MTHI/MTLO: 1 cycle. The new value is visible on `hi`/`lo` the next cycle.
- Back-to-back MDU ops:
  - The next op enters EX in the cycle after DONE and finds IDLE.
  - No extra bubble beyond the required DONE cycle.
- `busy` is combinational from `op_valid`/`op`/state. It contains no path from `source_a`/`source_b`.

## Configuration
- `MDU_DIV_EN` defined: the divider is built and DIV/DIVU behave as above.
- `MDU_DIV_EN` undefined:
  - No divider logic is built.
  - DIV/DIVU are accepted in IDLE, never stall, and leave HI/LO unchanged.
  - The DIV state is unreachable and optimized out.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_t` enum.
  - `mdu_state_t` enum.
  - Localparam for the 64-bit product width.
  - Decode from `W_FUNC` to `mdu_op_t` lives in ID, not here.
- Sub-module `div_iter`:
  - Unsigned restoring divider with start, shift/subtract per cycle, and done pulse after `DIV_CYCLES` cycles.
  - Sign handling stays in `muldiv`.
  - Instantiated only under `MDU_DIV_EN`.

## Test plan
- Reset, then hold `rst_n`=0 for 2 cycles → `hi`=0, `lo`=0, `busy`=0.
- MULT a=0xFFFFFFFE (−2), b=3 → `busy` high for 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → `busy` high for 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. MTHI 0x12345678 immediately after DONE → HI=0x12345678 next cycle, with no stall.
- DIV started, `flush` at iteration 10 → state returns to IDLE next cycle, `busy`=0, HI/LO keep their prior values. Assert `rst_n`=0 mid-MUL → the same abort behaviour.
- Build without `MDU_DIV_EN`: DIVU 10/3 → `busy` never rises, HI/LO unchanged. MULTU 0x10000×0x10000 → HI=1, LO=0.
